fetch_unit: RTL and testbench

Instruction fetch stage for the LAPI DOpaCA LAMBA core. It is the producer side of the opcode path: it holds the PC and fetches words from instruction memory over a req/ack handshake. It fills the IF/ID pipeline register whose opcode field drives the control unit in decode. It honours stall and flush from the hazard logic and PC redirects from branch/jump resolution.

---
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master: it drives req/addr and receives ack/rdata.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   ack;
    logic [INSTR_WIDTH-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus and fills IF/ID.
// Honours stall/flush from hazard logic and PC redirects from branch resolution.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    fetch_unit_if.master           imem,
    output logic                   if_id_valid,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [5:0]             if_id_opcode,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [PC_WIDTH-1:0]    if_id_pc_plus4
);

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(3'd4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(2'd3);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [PC_WIDTH-1:0]    pc_r, pc_next_s;
    logic [PC_WIDTH-1:0]    rpc_r, rpc_next_s;
    logic [INSTR_WIDTH-1:0] buf_instr_r, buf_instr_next_s;
    logic [PC_WIDTH-1:0]    buf_pc_r, buf_pc_next_s;
    logic                   load_s;
    logic [INSTR_WIDTH-1:0] load_instr_s;
    logic [PC_WIDTH-1:0]    load_pc_s;
    logic [PC_WIDTH-1:0]    target_s;
    logic [PC_WIDTH-1:0]    pc_plus4_s;

    logic                   if_id_valid_r;
    logic [INSTR_WIDTH-1:0] if_id_instr_r;
    logic [PC_WIDTH-1:0]    if_id_pc_r;
    logic [PC_WIDTH-1:0]    if_id_pc_plus4_r;

    assign target_s   = redirect_pc & ALIGN_MASK;
    assign pc_plus4_s = pc_r + PC_STEP;

    // An in-flight request (FETCH or DRAIN) keeps req high with a stable address.
    assign imem.req  = ~rst & (state_r != ST_HOLD);
    assign imem.addr = pc_r;

    // Next-state, next-PC and IF/ID load selection.
    always_comb begin
        state_next_s     = state_r;
        pc_next_s        = pc_r;
        rpc_next_s       = rpc_r;
        buf_instr_next_s = buf_instr_r;
        buf_pc_next_s    = buf_pc_r;
        load_s           = 1'b0;
        load_instr_s     = {INSTR_WIDTH{1'b0}};
        load_pc_s        = pc_r;
        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (imem.ack) begin
                        pc_next_s = target_s;
                    end else begin
                        rpc_next_s   = target_s;
                        state_next_s = ST_DRAIN;
                    end
                end else if (imem.ack) begin
                    pc_next_s = pc_plus4_s;
                    if (stall) begin
                        buf_instr_next_s = imem.rdata;
                        buf_pc_next_s    = pc_r;
                        state_next_s     = ST_HOLD;
                    end else begin
                        load_s       = 1'b1;
                        load_instr_s = imem.rdata;
                        load_pc_s    = pc_r;
                    end
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The bus cannot be cancelled, so wait out the stale transfer and drop its data.
                if (imem.ack) begin
                    pc_next_s    = redirect_valid ? target_s : rpc_r;
                    state_next_s = ST_FETCH;
                end else if (redirect_valid) begin
                    rpc_next_s = target_s;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_next_s    = target_s;
                    state_next_s = ST_FETCH;
                end else if (!stall) begin
                    load_s       = 1'b1;
                    load_instr_s = buf_instr_r;
                    load_pc_s    = buf_pc_r;
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // FSM state, PC, pending redirect target and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            rpc_r       <= {PC_WIDTH{1'b0}};
            buf_instr_r <= {INSTR_WIDTH{1'b0}};
            buf_pc_r    <= {PC_WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            rpc_r       <= rpc_next_s;
            buf_instr_r <= buf_instr_next_s;
            buf_pc_r    <= buf_pc_next_s;
        end
    end

    // IF/ID pipeline register: flush beats stall beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid_r    <= 1'b0;
            if_id_instr_r    <= {INSTR_WIDTH{1'b0}};
            if_id_pc_r       <= {PC_WIDTH{1'b0}};
            if_id_pc_plus4_r <= {PC_WIDTH{1'b0}};
        end else if (flush) begin
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= {INSTR_WIDTH{1'b0}};
        end else if (!stall && load_s) begin
            if_id_valid_r    <= 1'b1;
            if_id_instr_r    <= load_instr_s;
            if_id_pc_r       <= load_pc_s;
            if_id_pc_plus4_r <= load_pc_s + PC_STEP;
        end
    end

    assign if_id_valid    = if_id_valid_r;
    assign if_id_instr    = if_id_instr_r;
    assign if_id_opcode   = if_id_instr_r[INSTR_WIDTH-1 -: 6];
    assign if_id_pc       = if_id_pc_r;
    assign if_id_pc_plus4 = if_id_pc_plus4_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_opcode;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;

    fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) ifc ();

    fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (ifc.master),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_opcode   (if_id_opcode),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus controls
    logic        drv_rst, drv_stall, drv_flush, drv_rv, drv_stale_ack;
    logic [31:0] drv_rpc;
    int          lat_sel;
    int          mem_lat;
    int          mem_cnt;

    // observations taken mid-cycle, before the active edge
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        exp_req;
    logic [31:0] exp_addr;

    // reference model: next fetch address, pending redirect, held-instruction queue, IF/ID
    logic [31:0] m_pc;
    logic        m_pending;
    logic [31:0] m_target;
    logic [31:0] m_held_instr[$];
    logic [31:0] m_held_pc[$];
    logic        m_valid;
    logic [31:0] m_instr, m_ifpc, m_ifpc4;

    function automatic int pick_lat();
        if (lat_sel < 0) return int'($urandom_range(0, 3));
        else return lat_sel;
    endfunction

    task automatic step();
        logic        ack_eff;
        logic        have_load;
        logic [31:0] ld_instr, ld_pc, tgt, rd;
        @(negedge clk);
        rst            = drv_rst;
        stall          = drv_stall;
        flush          = drv_flush;
        redirect_valid = drv_rv;
        redirect_pc    = drv_rpc;
        #1;
        obs_req  = ifc.req;
        obs_addr = ifc.addr;
        exp_req  = !drv_rst && (m_held_pc.size() == 0);
        exp_addr = m_pc;
        if (drv_rst) ifc.ack = drv_stale_ack;
        else ifc.ack = ifc.req && (mem_cnt >= mem_lat);
        rd        = 32'h8C00_0000 | ifc.addr;
        ifc.rdata = rd;
        ack_eff   = ifc.ack && exp_req;
        tgt       = drv_rpc & ~32'd3;
        have_load = 1'b0;
        ld_instr  = 32'd0;
        ld_pc     = 32'd0;
        @(posedge clk);
        if (drv_rst) begin
            m_pc = 32'd0; m_pending = 1'b0; m_target = 32'd0;
            m_held_instr.delete(); m_held_pc.delete();
            m_valid = 1'b0; m_instr = 32'd0; m_ifpc = 32'd0; m_ifpc4 = 32'd0;
        end else begin
            if (m_held_pc.size() != 0) begin
                if (drv_rv) begin
                    m_held_instr.delete(); m_held_pc.delete();
                    m_pc = tgt;
                end else if (!drv_stall) begin
                    have_load = 1'b1;
                    ld_instr  = m_held_instr.pop_front();
                    ld_pc     = m_held_pc.pop_front();
                end
            end else if (m_pending) begin
                if (drv_rv) m_target = tgt;
                if (ack_eff) begin m_pc = m_target; m_pending = 1'b0; end
            end else if (drv_rv) begin
                if (ack_eff) m_pc = tgt;
                else begin m_pending = 1'b1; m_target = tgt; end
            end else if (ack_eff) begin
                if (drv_stall) begin
                    m_held_instr.push_back(rd); m_held_pc.push_back(m_pc);
                end else begin
                    have_load = 1'b1; ld_instr = rd; ld_pc = m_pc;
                end
                m_pc = m_pc + 32'd4;
            end
            if (drv_flush) begin
                m_valid = 1'b0; m_instr = 32'd0;
            end else if (!drv_stall && have_load) begin
                m_valid = 1'b1; m_instr = ld_instr; m_ifpc = ld_pc; m_ifpc4 = ld_pc + 32'd4;
            end
        end
        if (drv_rst) begin
            mem_cnt = 0; mem_lat = pick_lat();
        end else if (ifc.ack) begin
            mem_cnt = 0; mem_lat = pick_lat();
        end else if (obs_req) begin
            mem_cnt = mem_cnt + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        drv_rst = 1'b0; drv_stall = 1'b0; drv_flush = 1'b0; drv_rv = 1'b0;
        drv_rpc = 32'd0; drv_stale_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        lat_sel = 0;
        drv_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", obs_req); end
        end
        checks++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4} !== 97'd0) begin
            errors++;
            $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc4=%h expected all zero", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(i * 4);
            step();
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== exp_pc) begin
                errors++; $display("FAIL zw_addr: got req=%b addr=%h expected req=1 addr=%h", obs_req, obs_addr, exp_pc);
            end
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc || if_id_opcode !== 6'b100011 ||
                if_id_instr !== (32'h8C00_0000 | exp_pc) || if_id_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL zw_ifid: got v=%b pc=%h op=%b i=%h expected v=1 pc=%h op=100011", if_id_valid, if_id_pc, if_id_opcode, if_id_instr, exp_pc);
            end
        end
    endtask

    task automatic test_delayed_ack();
        idle_inputs();
        lat_sel = 3;
        drv_rv = 1'b1; drv_rpc = 32'h10; drv_flush = 1'b1;
        step();
        lat_sel = 0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
                errors++; $display("FAIL delay_addr: cycle %0d got req=%b addr=%h expected req=1 addr=00000010", i, obs_req, obs_addr);
            end
            checks++;
            if (i < 3 && if_id_valid !== 1'b0) begin
                errors++; $display("FAIL delay_wait_valid: cycle %0d got %b expected 0", i, if_id_valid);
            end else if (i == 3 && (if_id_valid !== 1'b1 || if_id_pc !== 32'h10)) begin
                errors++; $display("FAIL delay_load: got v=%b pc=%h expected v=1 pc=00000010", if_id_valid, if_id_pc);
            end
        end
    endtask

    task automatic test_stall_hold();
        idle_inputs();
        drv_rv = 1'b1; drv_rpc = 32'h20; drv_flush = 1'b1;
        step();
        idle_inputs();
        drv_stall = 1'b1;
        step();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h20 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL stall_first: got req=%b addr=%h v=%b expected req=1 addr=00000020 v=0", obs_req, obs_addr, if_id_valid);
        end
        step();
        checks++;
        if (obs_req !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold_req: got req=%b v=%b expected req=0 v=0", obs_req, if_id_valid);
        end
        drv_stall = 1'b0;
        step();
        checks++;
        if (obs_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h20) begin
            errors++; $display("FAIL stall_release: got req=%b v=%b pc=%h expected req=0 v=1 pc=00000020", obs_req, if_id_valid, if_id_pc);
        end
        step();
        checks++;
        if (obs_addr !== 32'h24 || if_id_pc !== 32'h24) begin
            errors++; $display("FAIL stall_next: got addr=%h pc=%h expected addr=00000024 pc=00000024", obs_addr, if_id_pc);
        end
    endtask

    task automatic test_redirect_drain();
        idle_inputs();
        lat_sel = 3;
        drv_rv = 1'b1; drv_rpc = 32'h40; drv_flush = 1'b1;
        step();
        lat_sel = 0;
        idle_inputs();
        drv_rv = 1'b1; drv_rpc = 32'h103;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h40 || if_id_valid !== 1'b0) begin
                errors++; $display("FAIL drain_hold: cycle %0d got req=%b addr=%h v=%b expected req=1 addr=00000040 v=0", i, obs_req, obs_addr, if_id_valid);
            end
        end
        step();
        checks++;
        if (obs_addr !== 32'h100 || if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin
            errors++; $display("FAIL drain_target: got addr=%h v=%b pc=%h expected addr=00000100 v=1 pc=00000100", obs_addr, if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        drv_flush = 1'b1; drv_stall = 1'b1;
        step();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_opcode !== 6'd0 || if_id_pc !== 32'h100) begin
            errors++; $display("FAIL flush_stall: got v=%b i=%h pc=%h expected v=0 i=00000000 pc=00000100", if_id_valid, if_id_instr, if_id_pc);
        end
        idle_inputs();
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h104) begin
            errors++; $display("FAIL flush_stall_release: got v=%b pc=%h expected v=1 pc=00000104", if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        idle_inputs();
        drv_rv = 1'b1; drv_rpc = 32'hFFFF_FFFC; drv_flush = 1'b1;
        step();
        idle_inputs();
        lat_sel = 3;
        step();
        checks++;
        if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'd0) begin
            errors++; $display("FAIL wrap_ifid: got pc=%h pc4=%h expected pc=fffffffc pc4=00000000", if_id_pc, if_id_pc_plus4);
        end
        lat_sel = 0;
        step();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'd0) begin
            errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=00000000", obs_req, obs_addr);
        end
        drv_rst = 1'b1; drv_stale_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_req !== 1'b0) begin errors++; $display("FAIL midreq_rst_req: got %b expected 0", obs_req); end
        end
        idle_inputs();
        step();
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'd0 || if_id_valid !== 1'b1 || if_id_pc !== 32'd0) begin
            errors++; $display("FAIL post_rst_fetch: got req=%b addr=%h v=%b pc=%h expected req=1 addr=0 v=1 pc=0", obs_req, obs_addr, if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp_op;
        lat_sel = -1;
        for (int n = 0; n < 600; n++) begin
            drv_rst       = ($urandom_range(0, 99) == 0);
            drv_stale_ack = $urandom_range(0, 1) == 1;
            drv_stall     = ($urandom_range(0, 9) < 3);
            drv_flush     = ($urandom_range(0, 9) == 0);
            drv_rv        = ($urandom_range(0, 7) == 0);
            drv_rpc       = $urandom();
            step();
            checks++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
                errors++; $display("FAIL rnd_bus: cycle %0d got req=%b addr=%h expected req=%b addr=%h", n, obs_req, obs_addr, exp_req, exp_addr);
            end
            exp_op = m_instr[31:26];
            checks++;
            if (if_id_valid !== m_valid || if_id_instr !== m_instr || if_id_opcode !== exp_op ||
                if_id_pc !== m_ifpc || if_id_pc_plus4 !== m_ifpc4) begin
                errors++;
                $display("FAIL rnd_ifid: cycle %0d got v=%b i=%h pc=%h pc4=%h expected v=%b i=%h pc=%h pc4=%h",
                         n, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, m_valid, m_instr, m_ifpc, m_ifpc4);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        ifc.ack = 1'b0; ifc.rdata = 32'd0;
        lat_sel = 0; mem_lat = 0; mem_cnt = 0;
        m_pc = 32'd0; m_pending = 1'b0; m_target = 32'd0;
        m_valid = 1'b0; m_instr = 32'd0; m_ifpc = 32'd0; m_ifpc4 = 32'd0;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_stall_hold();
        test_redirect_drain();
        test_flush_stall();
        test_wrap_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
